cacheline_adapter: RTL and testbench

Bridges the cache's 256-bit line-granular downward port to the 64-bit burst memory model. Sits directly below the cache: consumes the cache's `dfp_*` read/write requests, runs a 4-beat burst on `bmem_*`, and returns a full line with a one-cycle `dfp_resp`. Only one transaction is outstanding at a time. Writes complete when the last beat is accepted, not on memory acknowledgement.

---
 rtl/cache_types.sv | 12 +
 rtl/cacheline_adapter.sv | 118 +++++++++++
 tb/tb_cacheline_adapter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_types.sv
// Shared cache-side types; holds the state encoding of the line/burst adapter.
package cache_types;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_BURST,
        RESP
    } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts one cache-line read/writeback into a BEATS-long burst on the 64-bit memory port
// and hands back a full line with a single-cycle dfp_resp.
module cacheline_adapter
    import cache_types::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,

    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [ADDR_WIDTH-1:0] bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid
);

    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);

    adapter_state_t          state, state_n;
    logic [CNT_W-1:0]        cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH-1:0]   wline;
    logic [LINE_WIDTH-1:0]   rline;
    logic                    last_beat;
    logic                    beat_hit;
    logic [ADDR_WIDTH-1:0]   line_addr;

    // Byte offset within the line is never forwarded to memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^dfp_addr[OFF_W-1:0];

    assign line_addr = {dfp_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign last_beat = (cnt == CNT_W'(BEATS - 1));
    // Only beats tagged with our own line address belong to this transaction.
    assign beat_hit  = bmem_rvalid && (bmem_raddr == addr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            wline  <= '0;
            rline  <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (dfp_read || dfp_write) addr_q <= line_addr;
                    if (dfp_write)             wline  <= dfp_wdata;
                end
                RD_DATA: begin
                    if (beat_hit) begin
                        rline[int'(cnt)*BEAT_WIDTH +: BEAT_WIDTH] <= bmem_rdata;
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                    end
                end
                WR_BURST: begin
                    if (bmem_ready) cnt <= last_beat ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // All outputs come from registered state, so dfp_* never reaches bmem_* combinationally.
    always_comb begin
        state_n    = state;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        dfp_resp   = 1'b0;
        dfp_rdata  = '0;
        unique case (state)
            IDLE: begin
                if (dfp_write)     state_n = WR_BURST;
                else if (dfp_read) state_n = RD_REQ;
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
                if (bmem_ready) state_n = RD_DATA;
            end
            RD_DATA: begin
                if (beat_hit && last_beat) state_n = RESP;
            end
            WR_BURST: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = wline[int'(cnt)*BEAT_WIDTH +: BEAT_WIDTH];
                if (bmem_ready && last_beat) state_n = RESP;
            end
            RESP: begin
                dfp_resp  = 1'b1;
                dfp_rdata = rline;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Random and directed transactions against a line-granular memory model; every line and beat
// is predicted from the model and the cycle rules of the adapter.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read, dfp_write;
    logic [255:0] dfp_wdata, dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr, bmem_raddr;
    logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
    logic [63:0]  bmem_wdata, bmem_rdata;

    int n_vec = 0;
    int n_err = 0;

    logic [255:0] mem [logic [31:0]];

    cacheline_adapter #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .BEAT_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got hang exp completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic idle_bus();
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
    endtask

    // One cache transaction; the cache holds its request through the dfp_resp cycle.
    task automatic xact(input bit wr, input logic [31:0] addr, input logic [255:0] wdat,
                        input int rdy_pct, input logic [7:0] rpat, input bit use_pat,
                        input int gap_pct, input bit stray, input bit scramble);
        logic [31:0]  a;
        logic [255:0] line;
        int cyc, last, nacc, nbeat, nrd, k, issue_cyc;
        bit done, stray_left, rdy;
        a = {addr[31:5], 5'b0};
        if (wr) line = wdat;
        else begin
            if (!mem.exists(a)) mem[a] = rand256();
            line = mem[a];
        end
        cyc = 0; last = -100; nacc = 0; nbeat = 0; nrd = 0; k = 0; issue_cyc = -1;
        done = 1'b0; stray_left = stray;
        dfp_addr  = {addr[31:5], 5'($urandom)};
        dfp_write = wr;
        dfp_read  = wr ? 1'($urandom) : 1'b1;
        dfp_wdata = wr ? wdat : rand256();
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            bmem_ready  = 1'b0;
            bmem_rvalid = 1'b0;
            bmem_rdata  = {$urandom, $urandom};
            bmem_raddr  = $urandom;
            if (scramble) begin
                dfp_addr  = $urandom;
                dfp_wdata = rand256();
            end
            if (cyc == 1)
                chk("cmd_cycle1", 256'({bmem_read, bmem_write}), wr ? 256'(2'b01) : 256'(2'b10));
            rdy = use_pat ? rpat[k % 8] : ($urandom_range(0, 99) < rdy_pct);
            if (dfp_resp) begin
                chk("resp_cycle", 256'(cyc), 256'(last + 1));
                if (!wr) chk("rd_line", dfp_rdata, line);
                chk("bus_quiet_resp", 256'({bmem_read, bmem_write}), 256'(0));
                done = 1'b1;
            end else if (bmem_write) begin
                chk("wr_addr", 256'(bmem_addr), 256'(a));
                if (nacc < 4) chk("wr_beat", 256'(bmem_wdata), 256'(wdat[64*nacc +: 64]));
                k++;
                if (rdy) begin
                    bmem_ready = 1'b1;
                    nacc++;
                    if (nacc == 4) last = cyc;
                end
            end else if (bmem_read) begin
                chk("rd_addr", 256'(bmem_addr), 256'(a));
                k++;
                if (rdy) begin
                    bmem_ready = 1'b1;
                    nrd++;
                    issue_cyc = cyc;
                end
            end else begin
                chk("bus_idle", {160'd0, bmem_addr, bmem_wdata}, 256'(0));
            end
            if (issue_cyc >= 0 && cyc > issue_cyc && nbeat < 4 && !dfp_resp) begin
                if (stray_left && $urandom_range(0, 1) == 1) begin
                    bmem_rvalid = 1'b1;
                    bmem_raddr  = a ^ 32'h20;
                    stray_left  = 1'b0;
                end else if ($urandom_range(0, 99) >= gap_pct) begin
                    bmem_rvalid = 1'b1;
                    bmem_raddr  = a;
                    bmem_rdata  = line[64*nbeat +: 64];
                    nbeat++;
                    if (nbeat == 4) last = cyc;
                end
            end
        end
        chk("resp_seen", 256'(done), 256'(1));
        chk("wr_accepts", 256'(nacc), wr ? 256'(4) : 256'(0));
        chk("rd_cmds", 256'(nrd), wr ? 256'(0) : 256'(1));
        if (wr) mem[a] = wdat;
        idle_bus();
        @(posedge clk); #1;
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
    endtask

    // Read interrupted by reset after two beats; the rest of the burst arrives while idle.
    task automatic abort_read(input logic [31:0] a);
        int nbeat, cyc;
        bit issued;
        logic [255:0] line;
        line = rand256();
        mem[a] = line;
        nbeat = 0; cyc = 0; issued = 1'b0;
        dfp_addr = a; dfp_read = 1'b1; dfp_write = 1'b0; dfp_wdata = '0;
        while (nbeat < 2 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            idle_bus();
            if (issued) begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = a;
                bmem_rdata  = line[64*nbeat +: 64];
                nbeat++;
            end
            if (bmem_read) begin
                bmem_ready = 1'b1;
                issued = 1'b1;
            end
        end
        chk("abort_two_beats", 256'(nbeat), 256'(2));
        @(posedge clk); #1;
        rst = 1'b1; dfp_read = 1'b0;
        bmem_ready = 1'b0; bmem_rvalid = 1'b1; bmem_raddr = a; bmem_rdata = line[128 +: 64];
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_rst_ctl", 256'({dfp_resp, bmem_read, bmem_write}), 256'(0));
        chk("abort_rst_bus", {160'd0, bmem_addr, bmem_wdata}, 256'(0));
        chk("abort_rst_rdata", dfp_rdata, 256'(0));
        bmem_rvalid = 1'b1; bmem_raddr = a; bmem_rdata = line[192 +: 64];
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            idle_bus();
            chk("abort_no_resp", 256'({dfp_resp, bmem_read, bmem_write}), 256'(0));
        end
        mem[a] = rand256();
        xact(1'b0, a, '0, 70, 8'h00, 1'b0, 30, 1'b0, 1'b0);
    endtask

    initial begin
        logic [255:0] dline;
        logic [31:0]  ra;
        rst = 1'b1;
        dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        idle_bus();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", 256'({dfp_resp, bmem_read, bmem_write}), 256'(0));
        chk("reset_bus", {160'd0, bmem_addr, bmem_wdata}, 256'(0));
        chk("reset_rdata", dfp_rdata, 256'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed read: ready always high, beats back to back.
        mem[32'h1234_5660] = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        xact(1'b0, 32'h1234_5660, '0, 100, 8'h00, 1'b0, 0, 1'b0, 1'b0);

        // Directed write with ready pattern 1,0,1,1,0,1.
        dline = {64'hDEAD_3333_3333_BEEF, 64'hDEAD_2222_2222_BEEF,
                 64'hDEAD_1111_1111_BEEF, 64'hDEAD_0000_0000_BEEF};
        xact(1'b1, 32'h0000_0040, dline, 0, 8'b0010_1101, 1'b1, 0, 1'b0, 1'b0);

        // Gappy read with a stray beat tagged for another line.
        xact(1'b0, 32'h0000_1000, '0, 50, 8'h00, 1'b0, 50, 1'b1, 1'b0);

        // Writeback then immediate allocate, then read back the written line.
        xact(1'b1, 32'h0000_2000, rand256(), 100, 8'h00, 1'b0, 0, 1'b0, 1'b0);
        xact(1'b0, 32'h0000_3000, '0, 100, 8'h00, 1'b0, 0, 1'b0, 1'b0);
        xact(1'b0, 32'h0000_2000, '0, 100, 8'h00, 1'b0, 20, 1'b0, 1'b0);
        chk("readback_0x40", mem[32'h0000_0040], dline);
        xact(1'b0, 32'h0000_0040, '0, 80, 8'h00, 1'b0, 10, 1'b0, 1'b0);

        abort_read(32'h0000_5000);

        // Random mix over a small address pool so reads hit earlier writebacks.
        for (int t = 0; t < 40; t++) begin
            ra = 32'h0010_0000 + 32'($urandom_range(0, 5)) * 32'd32;
            xact(1'($urandom), ra, rand256(), $urandom_range(30, 100), 8'h00, 1'b0,
                 $urandom_range(0, 60), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
